// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave register map: write FSM states and
// default register-file geometry.
package i2c_pkg;

  localparam int unsigned NREG_DEFAULT    = 16;
  localparam int unsigned RO_BASE_DEFAULT = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GET_PTR = 2'd1,
    ST_WR_DATA = 2'd2
  } wr_state_e;

endpackage

// File: rtl/i2c_regmap.sv
// Byte-wide register map behind an I2C slave: auto-incrementing pointer,
// writable config registers, hardware-owned status registers, one-entry read buffer.
module i2c_regmap
  import i2c_pkg::*;
#(
  parameter int unsigned NREG    = NREG_DEFAULT,
  parameter int unsigned RO_BASE = RO_BASE_DEFAULT,
  localparam int unsigned AW     = $clog2(NREG)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_valid_i,
  input  logic                 rx_active_i,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  input  logic                 hw_we_i,
  input  logic [AW-1:0]        hw_addr_i,
  input  logic [7:0]           hw_wdata_i,
  output logic [8*RO_BASE-1:0] cfg_regs_o,
  output logic                 cfg_update_o,
  output logic [AW-1:0]        cfg_addr_o
);

  wr_state_e     state_q;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          rx_active_q;
  logic [7:0]    regs_q [NREG];
  logic [7:0]    tx_data_q;
  logic          tx_full_q;
  logic          cfg_update_q;
  logic [AW-1:0] cfg_addr_q;

  logic ptr_wr;
  logic cfg_we;
  logic hw_wr;
  logic tx_take;

  assign tx_valid_o = tx_full_q & ~rx_active_i;
  assign tx_take    = tx_valid_o & tx_ready_i;
  assign hw_wr      = hw_we_i & (32'(hw_addr_i) >= RO_BASE);

  // The write path owns the pointer whenever it moves it; a read handshake
  // in the same cycle (only possible as rx_active falls) loses.
  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    ptr_wr = 1'b0;
    cfg_we = 1'b0;
    ptr_d  = ptr_q;
    unique case (state_q)
      ST_GET_PTR: if (rx_valid_i) begin
        ptr_wr = 1'b1;
        ptr_d  = rx_data_i[AW-1:0];
      end
      ST_WR_DATA: if (rx_valid_i) begin
        ptr_wr = 1'b1;
        cfg_we = 32'(ptr_q) < RO_BASE;
        ptr_d  = ptr_q + AW'(1);
      end
      default: ;
    endcase
    if (!ptr_wr && tx_take) ptr_d = ptr_q + AW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      rx_active_q  <= 1'b0;
      tx_data_q    <= 8'h00;
      tx_full_q    <= 1'b0;
      cfg_update_q <= 1'b0;
      cfg_addr_q   <= '0;
    end else begin
      rx_active_q  <= rx_active_i;
      ptr_q        <= ptr_d;
      cfg_update_q <= cfg_we;
      if (cfg_we) cfg_addr_q <= ptr_q;

      unique case (state_q)
        ST_IDLE:    if (rx_active_i && !rx_active_q) state_q <= ST_GET_PTR;
        ST_GET_PTR: if (!rx_active_i) state_q <= ST_IDLE;
                    else if (rx_valid_i) state_q <= ST_WR_DATA;
        ST_WR_DATA: if (!rx_active_i) state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase

      // A moved pointer invalidates the buffered byte; it is refetched from the new address.
      if (ptr_wr || tx_take) begin
        tx_full_q <= 1'b0;
      end else if (!tx_full_q && !rx_active_i) begin
        tx_data_q <= regs_q[ptr_q];
        tx_full_q <= 1'b1;
      end
    end
  end

  // NOTE: the register array is reset because the register map must read 0x00 after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= 8'h00;
    end else begin
      if (cfg_we) regs_q[ptr_q] <= rx_data_i;
      if (hw_wr)  regs_q[hw_addr_i] <= hw_wdata_i;
    end
  end

  for (genvar k = 0; k < int'(RO_BASE); k++) begin : g_cfg
    assign cfg_regs_o[8*k +: 8] = regs_q[k];
  end

  assign tx_data_o    = tx_data_q;
  assign cfg_update_o = cfg_update_q;
  assign cfg_addr_o   = cfg_addr_q;

endmodule

// File: tb/tb_i2c_regmap.sv
// Directed bench for i2c_regmap: scoreboard queues for cfg_update and tx
// handshakes, plus direct checks of register image, pointer and reset.
module tb_i2c_regmap;
  import i2c_pkg::*;

  localparam int unsigned NREG    = NREG_DEFAULT;
  localparam int unsigned RO_BASE = RO_BASE_DEFAULT;
  localparam int unsigned AW      = $clog2(NREG);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [7:0]           rx_data = 8'h00;
  logic                 rx_valid = 1'b0;
  logic                 rx_active = 1'b0;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready = 1'b0;
  logic                 hw_we = 1'b0;
  logic [AW-1:0]        hw_addr = '0;
  logic [7:0]           hw_wdata = 8'h00;
  logic [8*RO_BASE-1:0] cfg_regs;
  logic                 cfg_update;
  logic [AW-1:0]        cfg_addr;

  i2c_regmap #(.NREG(NREG), .RO_BASE(RO_BASE)) dut (
    .clk_i(clk), .rst_i(rst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_active_i(rx_active),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .hw_we_i(hw_we), .hw_addr_i(hw_addr), .hw_wdata_i(hw_wdata),
    .cfg_regs_o(cfg_regs), .cfg_update_o(cfg_update), .cfg_addr_o(cfg_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_count = 0;
  int hs_prev = -1;
  int m_ptr = 0;
  logic [7:0] m_regs [NREG];
  int         cfg_q [$];
  logic [7:0] tx_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] cfg_byte(input int k);
    return cfg_regs[8*k +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs sampled on the falling edge, compared against queued expectations.
  always @(negedge clk) begin
    int e;
    if (!rst) begin
      if (cfg_update) begin
        chk("cfg_update_expected", 32'(cfg_q.size() > 0), 32'd1);
        if (cfg_q.size() > 0) begin
          e = cfg_q.pop_front();
          chk("cfg_addr", 32'(cfg_addr), 32'(e));
          chk("cfg_image", 32'(cfg_byte(e)), 32'(m_regs[e]));
        end
      end
      if (tx_valid && tx_ready) begin
        chk("tx_expected", 32'(tx_q.size() > 0), 32'd1);
        if (tx_q.size() > 0) chk("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
        if (hs_prev >= 0) chk("tx_gap", 32'(cyc - hs_prev), 32'd2);
        hs_prev = cyc;
        hs_count++;
      end
    end
  end

  // One master-write transaction: pointer byte then nbytes data bytes.
  task automatic wr_txn(input logic [7:0] ptr_byte, input int nbytes,
                        input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input bit fall_on_last);
    logic [7:0] d;
    rx_active = 1'b1;
    tick();
    rx_valid = 1'b1;
    rx_data  = ptr_byte;
    if (nbytes == 0 && fall_on_last) rx_active = 1'b0;
    m_ptr = int'(ptr_byte) % int'(NREG);
    tick();
    for (int i = 0; i < nbytes; i++) begin
      d = (i == 0) ? b0 : (i == 1) ? b1 : b2;
      rx_data = d;
      if (i == nbytes - 1 && fall_on_last) rx_active = 1'b0;
      if (m_ptr < int'(RO_BASE)) begin
        m_regs[m_ptr] = d;
        cfg_q.push_back(m_ptr);
      end
      m_ptr = (m_ptr + 1) % int'(NREG);
      tick();
    end
    if (fall_on_last) chk("fall_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    rx_active = 1'b0;
    tick();
  endtask

  task automatic hw_write(input int a, input logic [7:0] d);
    hw_we    = 1'b1;
    hw_addr  = AW'(a);
    hw_wdata = d;
    if (a >= int'(RO_BASE)) m_regs[a] = d;
    tick();
    hw_we = 1'b0;
  endtask

  task automatic rd_stream(input int n);
    int target;
    int budget;
    for (int i = 0; i < n; i++) begin
      tx_q.push_back(m_regs[m_ptr]);
      m_ptr = (m_ptr + 1) % int'(NREG);
    end
    target   = hs_count + n;
    hs_prev  = -1;
    budget   = 0;
    tx_ready = 1'b1;
    while (hs_count != target && budget < 10 * n + 10) begin
      tick();
      budget++;
    end
    tx_ready = 1'b0;
    chk("rd_count", 32'(hs_count), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < int'(NREG); i++) m_regs[i] = 8'h00;

    // Reset state
    tick();
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_cfg_update", 32'(cfg_update), 32'd0);
    chk("rst_cfg_addr", 32'(cfg_addr), 32'd0);
    chk("rst_cfg_regs", 32'(|cfg_regs), 32'd0);
    rst = 1'b0;
    tick(); tick();
    chk("idle_fetch_valid", 32'(tx_valid), 32'd1);

    // Basic write with auto-increment
    wr_txn(8'h03, 2, 8'hAA, 8'h55, 8'h00, 1'b0);
    chk("cfg3", 32'(cfg_byte(3)), 32'hAA);
    chk("cfg4", 32'(cfg_byte(4)), 32'h55);
    chk("ptr_after_36", 32'(dut.ptr_q), 32'd5);

    // Write to top status address is dropped, pointer wraps
    wr_txn(8'h0F, 1, 8'h11, 8'h00, 8'h00, 1'b0);
    chk("ptr_wrap", 32'(dut.ptr_q), 32'd0);
    chk("cfg0_untouched", 32'(cfg_byte(0)), 32'h00);

    // Config/status boundary: 11 written, 12 and 13 dropped
    wr_txn(8'h0B, 3, 8'hB0, 8'h99, 8'h22, 1'b0);
    chk("cfg11", 32'(cfg_byte(11)), 32'hB0);
    chk("ptr_after_boundary", 32'(dut.ptr_q), 32'd14);

    // Upper pointer bits ignored
    wr_txn(8'hF2, 1, 8'h3C, 8'h00, 8'h00, 1'b0);
    chk("cfg2", 32'(cfg_byte(2)), 32'h3C);

    // Hardware port: config address ignored, status addresses written
    hw_write(1, 8'hEE);
    hw_write(12, 8'h5A);
    hw_write(13, 8'h77);
    chk("hw_cfg1_ignored", 32'(cfg_byte(1)), 32'h00);

    // Streaming read from the status area
    wr_txn(8'h0C, 0, 8'h00, 8'h00, 8'h00, 1'b0);
    rd_stream(3);
    chk("ptr_after_read", 32'(dut.ptr_q), 32'd15);

    // Pointer write while a byte is buffered forces a refetch
    tick();
    chk("buf_valid_before", 32'(tx_valid), 32'd1);
    rx_active = 1'b1;
    #1;
    chk("tx_masked_active", 32'(tx_valid), 32'd0);
    tick();
    rx_valid = 1'b1;
    rx_data  = 8'h02;
    m_ptr    = 2;
    tick();
    rx_valid = 1'b0;
    chk("tx_masked_wr", 32'(tx_valid), 32'd0);
    rx_active = 1'b0;
    tick();
    chk("refetch_valid", 32'(tx_valid), 32'd1);
    chk("refetch_data", 32'(tx_data), 32'h3C);
    rd_stream(1);

    // rx_active without pointer change keeps the buffered byte
    tick();
    chk("buf_reg3", 32'(tx_data), 32'hAA);
    rx_active = 1'b1;
    tick(); tick();
    rx_active = 1'b0;
    #1;
    chk("kept_valid", 32'(tx_valid), 32'd1);
    chk("kept_data", 32'(tx_data), 32'hAA);
    tick();

    // Data byte coincident with rx_active falling
    wr_txn(8'h05, 1, 8'h66, 8'h00, 8'h00, 1'b1);
    chk("cfg5_fall", 32'(cfg_byte(5)), 32'h66);
    wr_txn(8'h05, 0, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("buf_reg5", 32'(tx_data), 32'h66);

    // Asynchronous reset in WR_DATA, right after a config write
    rx_active = 1'b1;
    tick();
    rx_valid = 1'b1;
    rx_data  = 8'h07;
    tick();
    rx_data = 8'h71;
    tick();
    rx_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    cfg_q.delete();
    for (int i = 0; i < int'(NREG); i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    chk("arst_cfg_update", 32'(cfg_update), 32'd0);
    chk("arst_cfg_addr", 32'(cfg_addr), 32'd0);
    chk("arst_cfg_regs", 32'(|cfg_regs), 32'd0);
    chk("arst_tx_data", 32'(tx_data), 32'h00);
    chk("arst_tx_valid", 32'(tx_valid), 32'd0);
    chk("arst_ptr", 32'(dut.ptr_q), 32'd0);
    chk("arst_state", 32'(dut.state_q), 32'(ST_IDLE));
    rx_active = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Normal operation after reset; status register cleared
    wr_txn(8'h01, 1, 8'h12, 8'h00, 8'h00, 1'b0);
    chk("post_rst_cfg1", 32'(cfg_byte(1)), 32'h12);
    chk("post_rst_cfg7", 32'(cfg_byte(7)), 32'h00);
    wr_txn(8'h0C, 0, 8'h00, 8'h00, 8'h00, 1'b0);
    rd_stream(1);

    tick(); tick();
    chk("cfg_q_drained", 32'(cfg_q.size()), 32'd0);
    chk("tx_q_drained", 32'(tx_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
